shift_frame_ctrl: RTL and testbench

SHIFT_FRAME_CTRL -- requirements
Module: shift_frame_ctrl

---
 rtl/shift_frame_pkg.sv | 17 +
 rtl/shift_reg_en.sv | 52 +++++
 rtl/shift_frame_ctrl.sv | 102 ++++++++++
 tb/tb_shift_frame_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/shift_frame_pkg.sv
// Shared definitions for the shift/LFSR frame controller: FSM states,
// default width, feedback taps and the substitute for an all-zero seed.
package shift_frame_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Feedback taps on bits 0, 2, 3 and 4.
    localparam logic [7:0] LFSR_TAPS     = 8'h1D;
    localparam logic [7:0] ZERO_SEED_SUB = 8'h01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_reg_en.sv
// Right-shifting register with shift enable, parallel load and an
// asynchronous active-high clear. New bits enter at the MSB.
module shift_reg_en
    import shift_frame_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_value,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] shifted;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_msb
                assign shifted[gi] = serial_in;
            end else begin : g_body
                assign shifted[gi] = q_reg[gi + 1];
            end
        end
    endgenerate

    // A load takes priority so a back-to-back frame starts from the seed.
    always_comb begin
        q_next = q_reg;
        if (load_en) begin
            q_next = load_value;
        end else if (shift_en) begin
            q_next = shifted;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/shift_frame_ctrl.sv
// Frame controller: captures or generates one WIDTH-bit word per start,
// then holds it until the consumer accepts it with ready.
module shift_frame_ctrl
    import shift_frame_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             r,
    input  logic             start,
    input  logic             si,
    input  logic             lfsr_mode,
    input  logic [WIDTH-1:0] seed,
    input  logic             ready,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] w,
    output logic [3:0]       count
);

    localparam logic [WIDTH-1:0] TAPS      = WIDTH'(LFSR_TAPS);
    localparam logic [WIDTH-1:0] SEED_SUB  = WIDTH'(ZERO_SEED_SUB);
    localparam logic [3:0]       LAST_CNT  = 4'(WIDTH - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [3:0]       count_reg;
    logic [3:0]       count_next;
    logic             mode_reg;
    logic             mode_next;
    logic             start_frame;
    logic             shift_en;
    logic             load_en;
    logic             serial_bit;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] w_q;

    always_ff @(posedge clock or posedge r) begin
        if (r) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (count_reg == LAST_CNT) state_next = HOLD;
            HOLD:    if (ready) state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A frame begins from IDLE, or straight out of HOLD when the word is taken.
    always_comb begin
        start_frame = ((state_reg == IDLE) && start) ||
                      ((state_reg == HOLD) && ready && start);
        shift_en    = (state_reg == SHIFT);
        load_en     = start_frame && lfsr_mode;
        busy        = (state_reg == SHIFT);
        valid       = (state_reg == HOLD);
        count_next  = count_reg;
        mode_next   = mode_reg;
        if (start_frame) begin
            count_next = '0;
            mode_next  = lfsr_mode;
        end else if (shift_en) begin
            count_next = count_reg + 4'd1;
        end
    end

    always_ff @(posedge clock or posedge r) begin
        if (r) begin
            count_reg <= '0;
            mode_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            mode_reg  <= mode_next;
        end
    end

    assign load_value = (seed == '0) ? SEED_SUB : seed;
    assign serial_bit = mode_reg ? (^(w_q & TAPS)) : si;

    shift_reg_en #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk        (clock),
        .clr        (r),
        .shift_en   (shift_en),
        .load_en    (load_en),
        .load_value (load_value),
        .serial_in  (serial_bit),
        .q          (w_q)
    );

    assign w     = w_q;
    assign count = count_reg;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Randomized self-checking bench for shift_frame_ctrl against a
// frame-level reference model of the capture/generate rules.
`timescale 1ns/1ps
module tb_shift_frame_ctrl;

    logic       clock = 1'b0;
    logic       r     = 1'b1;
    logic       start = 1'b0;
    logic       si    = 1'b0;
    logic       lfsr_mode = 1'b0;
    logic [7:0] seed  = 8'h00;
    logic       ready = 1'b0;
    logic       busy;
    logic       valid;
    logic [7:0] w;
    logic [3:0] count;

    int errors = 0;
    int checks = 0;
    logic [7:0] prev_w = 8'h00;

    shift_frame_ctrl #(.WIDTH(8)) dut (
        .clock     (clock),
        .r         (r),
        .start     (start),
        .si        (si),
        .lfsr_mode (lfsr_mode),
        .seed      (seed),
        .ready     (ready),
        .busy      (busy),
        .valid     (valid),
        .w         (w),
        .count     (count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: next LFSR word from the feedback rule w0^w2^w3^w4.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[4], v[7:1]};
    endfunction

    task automatic frame(input bit mode, input logic [7:0] sd, input logic [7:0] bits,
                         input bit from_hold, input bit noise);
        logic [7:0] cur;
        start = 1'b1; lfsr_mode = mode; seed = sd; ready = from_hold; si = 1'($urandom);
        tick();
        start = 1'b0; ready = 1'b0;
        cur = mode ? ((sd == 8'h00) ? 8'h01 : sd) : prev_w;
        chk("start_busy", busy, 1);
        chk("start_count", count, 0);
        chk("start_w", w, cur);
        for (int i = 0; i < 8; i++) begin
            si = bits[i];
            if (noise) begin
                start = 1'($urandom); lfsr_mode = 1'($urandom);
                seed = 8'($urandom); ready = 1'($urandom);
            end
            tick();
            cur = mode ? lfsr_next(cur) : {bits[i], cur[7:1]};
            chk("shift_w", w, cur);
            chk("shift_count", count, i + 1);
            chk("shift_busy", busy, (i < 7) ? 1 : 0);
            chk("shift_valid", valid, (i == 7) ? 1 : 0);
        end
        start = 1'b0; ready = 1'b0;
        prev_w = cur;
        $display("frame mode=%0d seed=%02h bits=%02h hold_in=%0d noise=%0d -> w=%02h exp=%02h",
                 mode, sd, bits, from_hold, noise, w, cur);
    endtask

    task automatic hold_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            ready = 1'b0; start = 1'($urandom); seed = 8'($urandom);
            tick();
            chk("hold_valid", valid, 1);
            chk("hold_busy", busy, 0);
            chk("hold_w", w, prev_w);
            chk("hold_count", count, 8);
        end
        start = 1'b0;
    endtask

    task automatic release_idle();
        ready = 1'b1; start = 1'b0;
        tick();
        ready = 1'b0;
        chk("rel_valid", valid, 0);
        chk("rel_busy", busy, 0);
        chk("rel_w", w, prev_w);
        for (int i = 0; i < 2; i++) begin
            lfsr_mode = 1'($urandom); seed = 8'($urandom);
            tick();
            chk("idle_busy", busy, 0);
            chk("idle_valid", valid, 0);
            chk("idle_w", w, prev_w);
            chk("idle_count", count, 8);
        end
        $display("release to idle w=%02h", w);
    endtask

    task automatic abort_frame();
        start = 1'b1; lfsr_mode = 1'($urandom); seed = 8'($urandom);
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("pre_abort_count", count, 4);
        #2 r = 1'b1;
        #1;
        chk("abort_w", w, 0);
        chk("abort_busy", busy, 0);
        chk("abort_valid", valid, 0);
        chk("abort_count", count, 0);
        @(posedge clock);
        #3 r = 1'b0;
        tick();
        chk("post_abort_busy", busy, 0);
        chk("post_abort_valid", valid, 0);
        chk("post_abort_w", w, 0);
        prev_w = 8'h00;
        $display("abort after 4 shifts, w=%02h", w);
    endtask

    initial begin
        bit in_hold;
        bit mode;
        logic [7:0] sd;
        #1;
        chk("rst_w", w, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_count", count, 0);
        #11 r = 1'b0;
        $display("reset released w=%02h", w);

        // Serial capture of 1,0,1,1,0,0,1,0 gives 8'h4D.
        frame(1'b0, 8'h00, 8'b0100_1101, 1'b0, 1'b0);
        chk("serial_4d", w, 8'h4D);
        hold_cycles(5);
        frame(1'b1, 8'h01, 8'h00, 1'b1, 1'b0);
        chk("lfsr01_final", w, 8'h71);
        release_idle();
        frame(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("lfsr00_final", w, 8'h71);
        release_idle();
        abort_frame();
        frame(1'b1, 8'hA5, 8'h00, 1'b0, 1'b1);
        hold_cycles(2);

        in_hold = 1'b1;
        for (int k = 0; k < 16; k++) begin
            mode = 1'($urandom);
            sd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            frame(mode, sd, 8'($urandom), in_hold, 1'($urandom));
            hold_cycles($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                in_hold = 1'b1;
            end else begin
                release_idle();
                in_hold = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
